column_move_reader: RTL and testbench

- Board-level consumer of the eight column move FIFOs. Each column FIFO presents the 152-bit read word, the empty flag and the read-enable port.
- Drains the columns in round-robin order and unpacks each 152-bit word into eight 19-bit move lanes.
- Drops lanes flagged invalid and emits the remaining moves as a single valid/ready stream toward the move-list store.
- Signals completion once every column reports done and every FIFO is drained.

---
 rtl/chess_move_pkg.sv | 35 +++
 rtl/move_word_unpacker.sv | 64 ++++++
 rtl/column_move_reader.sv | 132 +++++++++++++
 tb/tb_column_move_reader.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_move_pkg.sv
// Shared definitions for the column move readers: move layout, flag bit
// positions within the 7-bit flag field, and the scan FSM state encoding.
package chess_move_pkg;

  localparam int MW     = 19;
  localparam int LANES  = 8;
  localparam int NCOL   = 8;
  localparam int WORD_W = LANES * MW;

  // Move layout is {flag[6:0], from[5:0], to[5:0]}.
  localparam int FLAG_W   = 7;
  localparam int FLAG_LSB = MW - FLAG_W;

  localparam int FLAG_INVALID = 6;
  localparam int FLAG_PROMOTE = 5;
  localparam int FLAG_PAWN    = 4;
  localparam int FLAG_PAWN2   = 3;
  localparam int FLAG_EP      = 2;
  localparam int FLAG_CASTLE  = 1;
  localparam int FLAG_CAPTURE = 0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SCAN = 3'd1,
    S_WAIT = 3'd2,
    S_CAPT = 3'd3,
    S_UNPK = 3'd4,
    S_DONE = 3'd5
  } state_e;

  function automatic logic lane_is_invalid(input logic [MW-1:0] mv);
    return mv[FLAG_LSB + FLAG_INVALID];
  endfunction

endpackage

// File: rtl/move_word_unpacker.sv
// Holds one captured FIFO word and walks its eight lanes, skipping invalid
// lanes and presenting valid ones on a valid/ready handshake.
module move_word_unpacker
  import chess_move_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              move_ready_i,
  output logic [MW-1:0]     move_data_o,
  output logic              move_valid_o,
  output logic              last_lane_o
);

  logic [WORD_W-1:0] word_q, word_d;
  logic [2:0]        lane_q, lane_d;
  logic              active_q, active_d;
  logic [MW-1:0]     lane_s;
  logic              invalid_s;
  logic              advance_s;

  assign lane_s    = word_q[lane_q*MW +: MW];
  assign invalid_s = lane_is_invalid(lane_s);
  // A lane moves on when it is skipped or when the downstream takes it.
  assign advance_s = active_q && (invalid_s || move_ready_i);

  assign move_valid_o = active_q && !invalid_s;
  assign move_data_o  = move_valid_o ? lane_s : {MW{1'b0}};
  assign last_lane_o  = advance_s && (lane_q == 3'd7);

  always_comb begin
    word_d   = word_q;
    lane_d   = lane_q;
    active_d = active_q;
    if (load_i) begin
      word_d   = word_i;
      lane_d   = 3'd0;
      active_d = 1'b1;
    end else if (advance_s) begin
      lane_d = lane_q + 3'd1;
      if (lane_q == 3'd7) begin
        active_d = 1'b0;
      end else begin
        active_d = 1'b1;
      end
    end else begin
      lane_d = lane_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q   <= {WORD_W{1'b0}};
      lane_q   <= 3'd0;
      active_q <= 1'b0;
    end else begin
      word_q   <= word_d;
      lane_q   <= lane_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/column_move_reader.sv
// Round-robin drain of the column move FIFOs into one move stream.
// Optional COLUMN_MOVE_COUNT_EN adds a saturating 8-bit move_count output.
module column_move_reader
  import chess_move_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NCOL-1:0]        col_done,
  input  logic [NCOL-1:0]        col_empty,
  output logic [NCOL-1:0]        col_rden,
  input  logic [NCOL*WORD_W-1:0] col_data,
  output logic [MW-1:0]          move_data,
  output logic                   move_valid,
  input  logic                   move_ready,
  output logic                   busy,
  output logic                   done
`ifdef COLUMN_MOVE_COUNT_EN
  ,
  output logic [7:0]             move_count
`endif
);

  state_e            state_q, state_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [NCOL-1:0]   rden_q, rden_d;
  logic              load_s;
  logic              start_acc_s;
  logic              last_lane_s;
  logic              finished_s;
  logic [WORD_W-1:0] word_s;

  assign finished_s = (&col_done) && (&col_empty);
  assign word_s     = col_data[ptr_q*WORD_W +: WORD_W];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rden_d      = {NCOL{1'b0}};
    load_s      = 1'b0;
    start_acc_s = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_SCAN;
          ptr_d       = 3'd0;
          start_acc_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      S_SCAN: begin
        if (!col_empty[ptr_q]) begin
          rden_d  = {{(NCOL-1){1'b0}}, 1'b1} << ptr_q;
          state_d = S_WAIT;
        end else if (finished_s) begin
          state_d = S_DONE;
        end else begin
          ptr_d = ptr_q + 3'd1;
        end
      end
      // rden is registered, so the FIFO sees it during WAIT and q lands in CAPT.
      S_WAIT: state_d = S_CAPT;
      S_CAPT: begin
        load_s  = 1'b1;
        state_d = S_UNPK;
      end
      S_UNPK: begin
        if (last_lane_s) begin
          state_d = S_SCAN;
        end else begin
          state_d = S_UNPK;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= 3'd0;
      rden_q  <= {NCOL{1'b0}};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rden_q  <= rden_d;
    end
  end

  assign col_rden = rden_q;
  assign busy     = (state_q == S_SCAN) || (state_q == S_WAIT) ||
                    (state_q == S_CAPT) || (state_q == S_UNPK);
  assign done     = (state_q == S_DONE);

  move_word_unpacker u_unpacker (
    .clk          (clk),
    .reset        (reset),
    .load_i       (load_s),
    .word_i       (word_s),
    .move_ready_i (move_ready),
    .move_data_o  (move_data),
    .move_valid_o (move_valid),
    .last_lane_o  (last_lane_s)
  );

`ifdef COLUMN_MOVE_COUNT_EN
  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (start_acc_s) begin
      count_d = 8'd0;
    end else if (move_valid && move_ready && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign move_count = count_q;
`endif

endmodule

// File: tb/tb_column_move_reader.sv
// Directed bench for column_move_reader with a behavioural non-show-ahead
// FIFO per column; define COLUMN_MOVE_COUNT_EN to also check move_count.
module tb_column_move_reader;
  import chess_move_pkg::*;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   start = 1'b0;
  logic [NCOL-1:0]        col_done = 8'hFF;
  logic [NCOL-1:0]        col_empty;
  logic [NCOL-1:0]        col_rden;
  logic [NCOL*WORD_W-1:0] col_data;
  logic [MW-1:0]          move_data;
  logic                   move_valid;
  logic                   move_ready = 1'b1;
  logic                   busy;
  logic                   done;
`ifdef COLUMN_MOVE_COUNT_EN
  logic [7:0]             move_count;
`endif

  int check_cnt = 0;
  int pass_cnt  = 0;

  column_move_reader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .col_done   (col_done),
    .col_empty  (col_empty),
    .col_rden   (col_rden),
    .col_data   (col_data),
    .move_data  (move_data),
    .move_valid (move_valid),
    .move_ready (move_ready),
    .busy       (busy),
    .done       (done)
`ifdef COLUMN_MOVE_COUNT_EN
    ,
    .move_count (move_count)
`endif
  );

  always #5 clk = ~clk;

  // FIFO model: mem written by the stimulus, read pointer advanced on rden.
  logic [WORD_W-1:0] mem [NCOL][64];
  int                wr [NCOL];
  int                rd [NCOL];
  logic [WORD_W-1:0] qd [NCOL];
  int                rdlog [256];
  int                nlog = 0;
  int                multi_rd = 0;
  logic [MW-1:0]     emitted [1024];
  int                nemit = 0;
  logic [MW-1:0]     exp_q [$];

  initial begin
    for (int c = 0; c < NCOL; c++) begin
      wr[c] = 0;
      rd[c] = 0;
      qd[c] = '0;
    end
  end

  always_comb begin
    for (int c = 0; c < NCOL; c++) begin
      col_empty[c] = (rd[c] == wr[c]);
      col_data[c*WORD_W +: WORD_W] = qd[c];
    end
  end

  always @(posedge clk) begin
    if ($countones(col_rden) > 1) multi_rd <= multi_rd + 1;
    for (int c = 0; c < NCOL; c++) begin
      if (col_rden[c] && (rd[c] < wr[c])) begin
        qd[c]       <= mem[c][rd[c]];
        rd[c]       <= rd[c] + 1;
        rdlog[nlog] <= c;
        nlog        <= nlog + 1;
      end
    end
    if (!reset && move_valid && move_ready) begin
      emitted[nemit] <= move_data;
      nemit          <= nemit + 1;
    end
  end

  function automatic logic [MW-1:0] lane_val(input logic v, input int tag, input int i);
    logic [5:0] t;
    logic [5:0] l;
    t = tag[5:0];
    l = i[5:0];
    return {~v, 6'd0, t, l};
  endfunction

  function automatic logic [WORD_W-1:0] make_word(input logic [7:0] mask, input int tag);
    logic [WORD_W-1:0] w;
    for (int i = 0; i < LANES; i++) w[i*MW +: MW] = lane_val(mask[i], tag, i);
    return w;
  endfunction

  task automatic push_word(input int c, input logic [WORD_W-1:0] w);
    mem[c][wr[c]] = w;
    wr[c] = wr[c] + 1;
  endtask

  task automatic push_model(input int c, input logic [7:0] mask, input int tag);
    push_word(c, make_word(mask, tag));
  endtask

  task automatic add_exp(input logic [7:0] mask, input int tag);
    for (int i = 0; i < LANES; i++) if (mask[i]) exp_q.push_back(lane_val(1'b1, tag, i));
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_until_done(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (done) ok = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_cnt++; if (col_rden !== 8'h00) $display("FAIL reset_rden got %h want 00", col_rden); else pass_cnt++;
    check_cnt++; if (move_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", move_valid); else pass_cnt++;
    check_cnt++; if (move_data !== 19'h0) $display("FAIL reset_data got %h want 0", move_data); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    check_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
  endtask

  task automatic test_single_column();
    logic [WORD_W-1:0] w;
    logic ok;
    int e0, l0;
    for (int i = 0; i < LANES; i++) w[i*MW +: MW] = 19'h40000;
    w[18:0]  = 19'h00041;
    w[56:38] = 19'h10082;
    push_word(3, w);
    e0 = nemit; l0 = nlog;
    col_done = 8'hFF; move_ready = 1'b1;
    pulse_start();
    check_cnt++; if (busy !== 1'b1) $display("FAIL single_busy got %b want 1", busy); else pass_cnt++;
    run_until_done(200, ok);
    check_cnt++; if (ok !== 1'b1) $display("FAIL single_timeout got done=%b want 1", done); else pass_cnt++;
    check_cnt++; if (nemit - e0 != 2) $display("FAIL single_count got %0d want 2", nemit - e0); else pass_cnt++;
    check_cnt++; if (emitted[e0] !== 19'h00041) $display("FAIL single_mv0 got %h want 00041", emitted[e0]); else pass_cnt++;
    check_cnt++; if (emitted[e0+1] !== 19'h10082) $display("FAIL single_mv1 got %h want 10082", emitted[e0+1]); else pass_cnt++;
    check_cnt++; if ((nlog - l0 != 1) || (rdlog[l0] != 3)) $display("FAIL single_reads got n=%0d col=%0d want n=1 col=3", nlog - l0, rdlog[l0]); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("FAIL single_done_busy got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_two_columns();
    logic ok;
    int e0, l0, bad;
    exp_q.delete();
    push_model(0, 8'hA5, 10); push_model(0, 8'hFF, 11);
    push_model(7, 8'h3C, 12); push_model(7, 8'h00, 13);
    add_exp(8'hA5, 10); add_exp(8'hFF, 11); add_exp(8'h3C, 12); add_exp(8'h00, 13);
    e0 = nemit; l0 = nlog;
    pulse_start();
    run_until_done(300, ok);
    check_cnt++; if (ok !== 1'b1) $display("FAIL two_timeout got done=%b want 1", done); else pass_cnt++;
    check_cnt++; if ((nlog - l0 != 4) || (rdlog[l0] != 0) || (rdlog[l0+1] != 0) || (rdlog[l0+2] != 7) || (rdlog[l0+3] != 7))
      $display("FAIL two_read_order got n=%0d %0d %0d %0d %0d want 4 0 0 7 7", nlog - l0, rdlog[l0], rdlog[l0+1], rdlog[l0+2], rdlog[l0+3]);
    else pass_cnt++;
    check_cnt++; if (nemit - e0 != exp_q.size()) $display("FAIL two_count got %0d want %0d", nemit - e0, exp_q.size()); else pass_cnt++;
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++) if (emitted[e0+i] !== exp_q[i]) bad++;
    check_cnt++; if (bad != 0) $display("FAIL two_sequence got %0d wrong moves want 0", bad); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic ok, seen;
    int e0, l0, unstable, rd_seen;
    logic [MW-1:0] held;
    push_model(1, 8'h03, 20);
    e0 = nemit; l0 = nlog;
    move_ready = 1'b0;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (move_valid) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check_cnt++; if (seen !== 1'b1) $display("FAIL stall_valid got %b want 1", seen); else pass_cnt++;
    held = move_data;
    check_cnt++; if (held !== lane_val(1'b1, 20, 0)) $display("FAIL stall_data got %h want %h", held, lane_val(1'b1, 20, 0)); else pass_cnt++;
    unstable = 0; rd_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ((move_valid !== 1'b1) || (move_data !== held)) unstable++;
      if (col_rden !== 8'h00) rd_seen++;
    end
    check_cnt++; if (unstable != 0) $display("FAIL stall_stable got %0d unstable cycles want 0", unstable); else pass_cnt++;
    check_cnt++; if ((rd_seen != 0) || (nlog - l0 != 1)) $display("FAIL stall_no_read got %0d rden cycles want 0", rd_seen); else pass_cnt++;
    check_cnt++; if (nemit != e0) $display("FAIL stall_no_emit got %0d want 0", nemit - e0); else pass_cnt++;
    move_ready = 1'b1;
    run_until_done(100, ok);
    check_cnt++; if ((nemit - e0 != 2) || (emitted[e0+1] !== lane_val(1'b1, 20, 1)))
      $display("FAIL stall_resume got n=%0d mv1=%h want n=2 mv1=%h", nemit - e0, emitted[e0+1], lane_val(1'b1, 20, 1));
    else pass_cnt++;
  endtask

  task automatic test_wait_for_done();
    int l0, notbusy;
    col_done = 8'h7F;
    l0 = nlog;
    pulse_start();
    notbusy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((busy !== 1'b1) || (done !== 1'b0)) notbusy++;
    end
    check_cnt++; if (notbusy != 0) $display("FAIL hold_scan got %0d bad cycles want 0", notbusy); else pass_cnt++;
    check_cnt++; if (nlog != l0) $display("FAIL hold_no_read got %0d reads want 0", nlog - l0); else pass_cnt++;
    col_done = 8'hFF;
    @(negedge clk);
    check_cnt++; if (done !== 1'b1) $display("FAIL hold_release got done=%b want 1", done); else pass_cnt++;
  endtask

  task automatic test_reset_mid_pass();
    logic ok, seen;
    int e0, l0;
    push_model(2, 8'hFF, 30);
    move_ready = 1'b1;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (move_valid && (move_data === lane_val(1'b1, 30, 4))) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check_cnt++; if (seen !== 1'b1) $display("FAIL midrst_reach got %b want 1", seen); else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    check_cnt++; if ((move_valid !== 1'b0) || (busy !== 1'b0) || (col_rden !== 8'h00) || (done !== 1'b0))
      $display("FAIL midrst_state got valid=%b busy=%b rden=%h done=%b want 0 0 00 0", move_valid, busy, col_rden, done);
    else pass_cnt++;
    reset = 1'b0;
    push_model(0, 8'h01, 31);
    push_model(5, 8'h80, 32);
    e0 = nemit; l0 = nlog;
    pulse_start();
    run_until_done(200, ok);
    check_cnt++; if ((nlog - l0 != 2) || (rdlog[l0] != 0) || (rdlog[l0+1] != 5))
      $display("FAIL midrst_restart got n=%0d first=%0d second=%0d want 2 0 5", nlog - l0, rdlog[l0], rdlog[l0+1]);
    else pass_cnt++;
    check_cnt++; if ((nemit - e0 != 2) || (emitted[e0] !== lane_val(1'b1, 31, 0)) || (emitted[e0+1] !== lane_val(1'b1, 32, 7)))
      $display("FAIL midrst_moves got n=%0d %h %h want 2 %h %h", nemit - e0, emitted[e0], emitted[e0+1], lane_val(1'b1, 31, 0), lane_val(1'b1, 32, 7));
    else pass_cnt++;
  endtask

  task automatic test_many_moves();
    logic ok;
    int e0, bad;
    logic [7:0] m;
    exp_q.delete();
    for (int k = 0; k < 38; k++) begin
      m = (k < 37) ? 8'hFF : 8'h0F;
      push_model(k % 8, m, 40 + k);
    end
    for (int c = 0; c < NCOL; c++)
      for (int k = c; k < 38; k += 8) begin
        m = (k < 37) ? 8'hFF : 8'h0F;
        add_exp(m, 40 + k);
      end
    e0 = nemit;
    pulse_start();
    run_until_done(3000, ok);
    check_cnt++; if (ok !== 1'b1) $display("FAIL many_timeout got done=%b want 1", done); else pass_cnt++;
    check_cnt++; if (nemit - e0 != 300) $display("FAIL many_count got %0d want 300", nemit - e0); else pass_cnt++;
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++) if (emitted[e0+i] !== exp_q[i]) bad++;
    check_cnt++; if (bad != 0) $display("FAIL many_sequence got %0d wrong moves want 0", bad); else pass_cnt++;
`ifdef COLUMN_MOVE_COUNT_EN
    check_cnt++; if (move_count !== 8'd255) $display("FAIL count_sat got %0d want 255", move_count); else pass_cnt++;
    pulse_start();
    check_cnt++; if (move_count !== 8'd0) $display("FAIL count_clear got %0d want 0", move_count); else pass_cnt++;
    repeat (20) @(negedge clk);
`endif
    check_cnt++; if (multi_rd != 0) $display("FAIL one_hot_rden got %0d multi-bit cycles want 0", multi_rd); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_column();
    test_two_columns();
    test_backpressure();
    test_wait_for_done();
    test_reset_mid_pass();
    test_many_moves();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
